// File: rtl/shift_sequencer_if.sv
// Parallel-side bus of the shift sequencer.
// Carries the transmit handshake (tx_valid/tx_ready/tx_data) and the
// receive result (rx_valid strobe + rx_data).
//   master : parallel logic that offers words and consumes results
//   slave  : the shift sequencer
interface shift_sequencer_if #(
  parameter int N = 8
);
  logic         tx_valid;
  logic         tx_ready;
  logic [N-1:0] tx_data;
  logic         rx_valid;
  logic [N-1:0] rx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  rx_valid,
    input  rx_data
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output rx_valid,
    output rx_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Serial transfer engine (SPI-mode-0-like) built around one N-bit shift
// register. A word accepted on the tx handshake is shifted out MSB-first on
// o_sout while i_sin is captured into the vacated LSB, so after N bits the
// same register holds the received word, which is published on rx_data with
// a one-cycle rx_valid strobe.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high reset
//   bus      : slave side of shift_sequencer_if (tx handshake, rx result)
//   i_sin    : serial data in, sampled on o_sclk rising
//   o_sout   : serial data out, valid from the first shift cycle
//   o_sclk   : generated serial clock, BIT_CLKS clk cycles per bit
//   o_frame  : active-high chip select for the whole shift phase
//   o_busy   : high while shifting and in the completion cycle
// All outputs are registers; their next values are derived from the
// next-state values so they line up exactly with the state they describe.
module shift_sequencer #(
  parameter int N        = 8,
  parameter int BIT_CLKS = 4
) (
  input  logic                clk,
  input  logic                reset,
  shift_sequencer_if.slave    bus,
  input  logic                i_sin,
  output logic                o_sout,
  output logic                o_sclk,
  output logic                o_frame,
  output logic                o_busy
);

  localparam int BW = $clog2(N);
  localparam int DW = $clog2(BIT_CLKS);

  localparam logic [BW-1:0] BIT_LAST    = BW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(BIT_CLKS - 1);
  localparam logic [DW-1:0] DIV_HALF_M1 = DW'(BIT_CLKS / 2 - 1);
  localparam logic [DW-1:0] DIV_HALF    = DW'(BIT_CLKS / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_shreg;
  logic [BW-1:0] r_bit_cnt;
  logic [DW-1:0] r_div_cnt;
  logic          r_sample;
  logic [N-1:0]  r_rx_data;
  logic          r_rx_valid;
  logic          r_sout;
  logic          r_sclk;
  logic          r_frame;
  logic          r_busy;
  logic          r_tx_ready;

  state_t        w_state_nxt;
  logic [N-1:0]  w_shreg_nxt;
  logic [BW-1:0] w_bit_nxt;
  logic [DW-1:0] w_div_nxt;
  logic          w_sample_nxt;
  logic [N-1:0]  w_rx_data_nxt;
  logic          w_rx_valid_nxt;
  logic          w_sout_nxt;
  logic          w_sclk_nxt;
  logic          w_frame_nxt;
  logic          w_busy_nxt;
  logic          w_tx_ready_nxt;

  // Next-state and datapath sequencing.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_nxt     = r_bit_cnt;
    w_div_nxt     = r_div_cnt;
    w_sample_nxt  = r_sample;
    w_rx_data_nxt = r_rx_data;
    case (r_state)
      S_IDLE: begin
        if (bus.tx_valid && r_tx_ready) begin
          w_shreg_nxt = bus.tx_data;
          w_bit_nxt   = '0;
          w_div_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        // Capture sin on the clk edge that raises sclk; the shift happens a
        // half bit later so sout changes while sclk is low.
        if (r_div_cnt == DIV_HALF_M1) begin
          w_sample_nxt = i_sin;
        end else begin
          w_sample_nxt = r_sample;
        end
        if (r_div_cnt == DIV_LAST) begin
          w_div_nxt   = '0;
          w_shreg_nxt = {r_shreg[N-2:0], r_sample};
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_nxt     = '0;
            w_state_nxt   = S_DONE;
            w_rx_data_nxt = {r_shreg[N-2:0], r_sample};
          end else begin
            w_bit_nxt = r_bit_cnt + BW'(1);
          end
        end else begin
          w_div_nxt = r_div_cnt + DW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    w_tx_ready_nxt = (w_state_nxt == S_IDLE);
    w_frame_nxt    = (w_state_nxt == S_SHIFT);
    w_busy_nxt     = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_DONE);
    w_rx_valid_nxt = (w_state_nxt == S_DONE);
    if (w_state_nxt == S_SHIFT) begin
      w_sout_nxt = w_shreg_nxt[N-1];
      w_sclk_nxt = (w_div_nxt >= DIV_HALF);
    end else begin
      w_sout_nxt = 1'b0;
      w_sclk_nxt = 1'b0;
    end
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_sample   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sout     <= 1'b0;
      r_sclk     <= 1'b0;
      r_frame    <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_div_cnt  <= w_div_nxt;
      r_sample   <= w_sample_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_sout     <= w_sout_nxt;
      r_sclk     <= w_sclk_nxt;
      r_frame    <= w_frame_nxt;
      r_busy     <= w_busy_nxt;
      r_tx_ready <= w_tx_ready_nxt;
    end
  end

  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data  = r_rx_data;
  assign o_sout       = r_sout;
  assign o_sclk       = r_sclk;
  assign o_frame      = r_frame;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer (N=8, BIT_CLKS=4). Inputs are driven and outputs
// sampled on the falling clk edge. Expected serial waveforms and received
// words come from the transfer rules: bit i of a word occupies shift cycles
// i*B .. i*B+B-1 (MSB first), sclk is high in the upper half of each bit,
// and sin is taken from the last low-sclk cycle of each bit.
module tb_shift_sequencer;
  localparam int N = 8;
  localparam int B = 4;

  logic clk = 1'b0;
  logic reset;
  logic tb_sin;
  logic loop_en;
  logic w_sin;
  logic o_sout, o_sclk, o_frame, o_busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int hs_cyc;

  shift_sequencer_if #(.N(N)) bus ();

  shift_sequencer #(.N(N), .BIT_CLKS(B)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .i_sin   (w_sin),
    .o_sout  (o_sout),
    .o_sclk  (o_sclk),
    .o_frame (o_frame),
    .o_busy  (o_busy)
  );

  assign w_sin = loop_en ? o_sout : tb_sin;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One complete transfer starting from an IDLE falling edge.
  // mode 0: loopback; 1: sin = rxpat at sample points, random elsewhere;
  // 2: sin = rxpat at sample points, 1 elsewhere. hold keeps tx_valid high.
  task automatic do_transfer(input logic [N-1:0] tx, input int mode,
                             input logic [N-1:0] rxpat, input bit hold,
                             input string tag);
    logic [N-1:0] exp_rx;
    logic         exp_sout;
    logic         exp_sclk;
    exp_rx  = (mode == 0) ? tx : rxpat;
    loop_en = (mode == 0);
    n_vec++;
    if (bus.tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_ready: got %b want 1", tag, bus.tx_ready);
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = tx;
    hs_cyc       = cyc;
    for (int k = 0; k < N * B; k++) begin
      @(negedge clk);
      if (hold) bus.tx_data = N'($urandom);
      else      bus.tx_valid = 1'b0;
      exp_sout = tx[N - 1 - k / B];
      exp_sclk = ((k % B) >= B / 2);
      n_vec++;
      if ({o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid} !==
          {exp_sout, exp_sclk, 4'b1100}) begin
        n_err++;
        $display("FAIL %s shift k=%0d sout/sclk/frame/busy/rdy/rxv: got %b%b%b%b%b%b want %b%b1100",
                 tag, k, o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid,
                 exp_sout, exp_sclk);
      end
      if (mode != 0) begin
        if ((k % B) == (B / 2 - 1)) tb_sin = rxpat[N - 1 - k / B];
        else                         tb_sin = (mode == 1) ? 1'($urandom) : 1'b1;
      end
    end
    @(negedge clk);
    if (hold) bus.tx_data = N'($urandom);
    n_vec++;
    if ({o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid} !== 6'b000101 ||
        bus.rx_data !== exp_rx) begin
      n_err++;
      $display("FAIL %s done sout/sclk/frame/busy/rdy/rxv=%b%b%b%b%b%b rx=%h want 000101 rx=%h",
               tag, o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid,
               bus.rx_data, exp_rx);
    end
    @(negedge clk);
    n_vec++;
    if ({o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid} !== 6'b000010 ||
        bus.rx_data !== exp_rx) begin
      n_err++;
      $display("FAIL %s after sout/sclk/frame/busy/rdy/rxv=%b%b%b%b%b%b rx=%h want 000010 rx=%h",
               tag, o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid,
               bus.rx_data, exp_rx);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    tb_sin       = 1'b0;
    loop_en      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid} !== 6'b000010 ||
        bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset sout/sclk/frame/busy/rdy/rxv=%b%b%b%b%b%b rx=%h want 000010 rx=00",
               o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid, bus.rx_data);
    end
  endtask

  task automatic test_loopback();
    do_transfer(8'hA5, 0, 8'h00, 1'b0, "loop_a5");
  endtask

  task automatic test_model_rx();
    do_transfer(8'hFF, 1, 8'h3C, 1'b0, "model_3c");
  endtask

  task automatic test_back_to_back();
    int hs1;
    do_transfer(8'h01, 0, 8'h00, 1'b1, "b2b_01");
    hs1 = hs_cyc;
    do_transfer(8'h80, 0, 8'h00, 1'b0, "b2b_80");
    n_vec++;
    if (hs_cyc - hs1 !== N * B + 2) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d cycles want %0d", hs_cyc - hs1, N * B + 2);
    end
  endtask

  task automatic test_reset_abort();
    loop_en      = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hC3;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (4 * B) @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid} !== 6'b000010 ||
        bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL abort_async sout/sclk/frame/busy/rdy/rxv=%b%b%b%b%b%b rx=%h want 000010 rx=00",
               o_sout, o_sclk, o_frame, o_busy, bus.tx_ready, bus.rx_valid, bus.rx_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N * B; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.rx_valid !== 1'b0 || o_frame !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet i=%0d rxv=%b frame=%b want 0 0", i, bus.rx_valid, o_frame);
      end
    end
    do_transfer(8'h5A, 1, 8'h96, 1'b0, "abort_next");
  endtask

  task automatic test_glitch();
    do_transfer(8'h6E, 2, 8'h00, 1'b0, "glitch");
  endtask

  task automatic test_random();
    logic [N-1:0] tx;
    logic [N-1:0] rp;
    for (int t = 0; t < 8; t++) begin
      tx = N'($urandom);
      rp = N'($urandom);
      do_transfer(tx, int'($urandom_range(0, 1)), rp, 1'b0, "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_model_rx();
    test_back_to_back();
    test_reset_abort();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
